// File: rtl/alg_thresh_sched.sv
// Peak-to-threshold scheduler: accept a peak, compute gate thresholds, write them out; 2 cycles accept->write, 3-cycle min spacing.
// peak_ready low while busy; write holds until th_wr_ready. Define ALG_CLAMP_EN to clamp the window inside [0, 2^Np-1].
module alg_thresh_sched #(
   parameter int Nb        = 6,
   parameter int Np        = 12,
   parameter int PIXEL_NUM = 16,
   parameter int PW        = 4
) (
   input  logic          clk,
   input  logic          res,
   input  logic          frame_start,
   input  logic          peak_valid,
   input  logic [Nb-1:0] peak_ch,
   input  logic [PW-1:0] peak_pix,
   output logic          peak_ready,
   output logic          th_wr_en,
   input  logic          th_wr_ready,
   output logic [PW-1:0] th_wr_addr,
   output logic [Np-1:0] th_minus,
   output logic [Np-1:0] th_positive,
   output logic [Np-1:0] th_delta,
   output logic          frame_done,
   output logic          err_pix
);

   localparam logic [Np-1:0] SB   = {{(Np-1){1'b0}}, 1'b1} << (Np - Nb);
   localparam logic [Np-1:0] HALF = SB >> 1;
   localparam logic [Np-1:0] UB   = '1;
   localparam logic [PW:0]   PN   = (PW+1)'(PIXEL_NUM);

   typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

   state_t        state, state_nx;
   logic          rdy_ok;
   logic          accept;
   logic          wr_done;
   logic          pix_ok;
   logic [Nb-1:0] cap_ch;
   logic [PW-1:0] cap_pix;
   logic [PW:0]   cnt;
   logic [Np-1:0] ch_c, mi, po, de;

   assign pix_ok  = ({1'b0, cap_pix} < PN);
   assign wr_done = th_wr_en & th_wr_ready;

   always_comb begin
      state_nx   = state;
      peak_ready = 1'b0;
      th_wr_en   = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            // rdy_ok keeps the first cycle after reset release closed
            peak_ready = rdy_ok;
            if (rdy_ok && peak_valid) begin
               accept   = 1'b1;
               state_nx = CALC;
            end
         end
         CALC:    state_nx = pix_ok ? WRITE : IDLE;
         WRITE: begin
            th_wr_en = 1'b1;
            if (th_wr_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ch_c = ({{(Np-Nb){1'b0}}, cap_ch} << (Np - Nb)) + HALF;
      mi   = ch_c - SB;
      po   = ch_c + SB;
`ifdef ALG_CLAMP_EN
      if (ch_c < SB) begin
         mi = '0;
         po = SB << 1;
      end else if (ch_c > UB - SB) begin
         po = UB;
         mi = UB - (SB << 1);
      end
`endif
      de = mi + po - ((po >> Nb) << Nb);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         rdy_ok      <= 1'b0;
         cap_ch      <= '0;
         cap_pix     <= '0;
         th_wr_addr  <= '0;
         th_minus    <= '0;
         th_positive <= '0;
         th_delta    <= '0;
      end else begin
         rdy_ok <= 1'b1;
         if (accept) begin
            cap_ch  <= peak_ch;
            cap_pix <= peak_pix;
         end
         if (state == CALC && pix_ok) begin
            th_wr_addr  <= cap_pix;
            th_minus    <= mi;
            th_positive <= po;
            th_delta    <= de;
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt        <= '0;
         frame_done <= 1'b0;
         err_pix    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // a frame_start on the same edge as the last write suppresses frame_done
         if (frame_start) begin
            cnt <= '0;
         end else if (wr_done) begin
            if (cnt + 1'b1 == PN) begin
               cnt        <= '0;
               frame_done <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (state == CALC && !pix_ok) err_pix <= 1'b1;
         else if (frame_start)         err_pix <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alg_thresh_sched.sv
// Directed bench for alg_thresh_sched with a transaction-level model checked every cycle.
module tb_alg_thresh_sched;
   localparam int NB = 6;
   localparam int NP = 12;
   localparam int PN = 16;
   localparam int PW = 5;

   logic          clk = 1'b0;
   logic          res = 1'b1;
   logic          frame_start = 1'b0;
   logic          peak_valid = 1'b0;
   logic          th_wr_ready = 1'b1;
   logic [NB-1:0] peak_ch = '0;
   logic [PW-1:0] peak_pix = '0;
   logic          peak_ready, th_wr_en, frame_done, err_pix;
   logic [PW-1:0] th_wr_addr;
   logic [NP-1:0] th_minus, th_positive, th_delta;

   int n_chk = 0;
   int n_fail = 0;
   int wr_cycles = 0;
   int done_cnt = 0;

   // model state: phase -1 idle, 0 computing, 1 writing
   int m_phase = -1;
   int m_cnt = 0;
   bit m_done = 0, m_err = 0, m_rdy = 0, m_bad = 0;
   int e_addr = 0, e_mi = 0, e_po = 0, e_de = 0;

   always #5 clk = ~clk;

   alg_thresh_sched #(.Nb(NB), .Np(NP), .PIXEL_NUM(PN), .PW(PW)) dut (
      .clk(clk), .res(res), .frame_start(frame_start),
      .peak_valid(peak_valid), .peak_ch(peak_ch), .peak_pix(peak_pix),
      .peak_ready(peak_ready), .th_wr_en(th_wr_en), .th_wr_ready(th_wr_ready),
      .th_wr_addr(th_wr_addr), .th_minus(th_minus), .th_positive(th_positive),
      .th_delta(th_delta), .frame_done(frame_done), .err_pix(err_pix)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void thresholds(input int ch, output int mi, output int po, output int de);
      int c, sb, ub;
      c  = ch * 64 + 32;
      sb = 64;
      ub = 4095;
`ifdef ALG_CLAMP_EN
      if (c < sb) begin
         mi = 0; po = 2 * sb;
      end else if (c > ub - sb) begin
         po = ub; mi = ub - 2 * sb;
      end else begin
         mi = c - sb; po = c + sb;
      end
`else
      mi = (c - sb + 4096) % 4096;
      po = (c + sb) % 4096;
`endif
      de = (mi + po - (po / 64) * 64) % 4096;
   endfunction

   always @(posedge clk or posedge res) begin
      bit wrote;
      if (res) begin
         m_phase = -1; m_cnt = 0; m_done = 0; m_err = 0; m_rdy = 0;
      end else begin
         wrote  = (m_phase == 1) && th_wr_ready;
         m_done = 0;
         if (frame_start) m_cnt = 0;
         else if (wrote) begin
            m_cnt++;
            if (m_cnt == PN) begin
               m_cnt = 0; m_done = 1;
            end
         end
         if (frame_start) m_err = 0;
         if (m_phase == 0 && m_bad) m_err = 1;
         if (m_phase == -1) begin
            if (m_rdy && peak_valid) begin
               thresholds(int'(peak_ch), e_mi, e_po, e_de);
               e_addr  = int'(peak_pix);
               m_bad   = int'(peak_pix) >= PN;
               m_phase = 0;
            end
         end else if (m_phase == 0) begin
            m_phase = m_bad ? -1 : 1;
         end else if (th_wr_ready) begin
            m_phase = -1;
         end
         m_rdy = 1;
      end
   end

   always @(negedge clk) begin
      if (!res) begin
         chk("peak_ready", int'(peak_ready), int'(m_rdy && m_phase == -1));
         chk("th_wr_en", int'(th_wr_en), int'(m_phase == 1));
         chk("frame_done", int'(frame_done), int'(m_done));
         chk("err_pix", int'(err_pix), int'(m_err));
         if (th_wr_en) begin
            wr_cycles++;
            chk("th_wr_addr", int'(th_wr_addr), e_addr);
            chk("th_minus", int'(th_minus), e_mi);
            chk("th_positive", int'(th_positive), e_po);
            chk("th_delta", int'(th_delta), e_de);
         end
         if (frame_done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input int pix);
      int n = 0;
      while (!peak_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", int'(peak_ready), 1);
      peak_ch    = NB'(ch);
      peak_pix   = PW'(pix);
      peak_valid = 1'b1;
      tick();
      peak_valid = 1'b0;
   endtask

   task automatic wr(input int ch, input int pix);
      send(ch, pix);
      tick();
      tick();
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int d, w0;
      #1;
      chk("rst_ready", int'(peak_ready), 0);
      chk("rst_wr_en", int'(th_wr_en), 0);
      chk("rst_minus", int'(th_minus), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_err", int'(err_pix), 0);
      tick(); tick();
      res = 1'b0;
      #1 chk("ready_before_edge", int'(peak_ready), 0);
      tick();
      chk("ready_after_edge", int'(peak_ready), 1);

      send(10, 3);
      chk("A_calc_no_wr", int'(th_wr_en), 0);
      tick();
      chk("A_wr_en", int'(th_wr_en), 1);
      chk("A_addr", int'(th_wr_addr), 3);
      chk("A_minus", int'(th_minus), 608);
      chk("A_pos", int'(th_positive), 736);
      chk("A_delta", int'(th_delta), 640);
      tick();
      chk("A_idle", int'(peak_ready), 1);

`ifdef ALG_CLAMP_EN
      send(0, 4); tick();
      chk("B0_minus", int'(th_minus), 0);
      chk("B0_pos", int'(th_positive), 128);
      chk("B0_delta", int'(th_delta), 0);
      tick();
      send(63, 5); tick();
      chk("B63_minus", int'(th_minus), 3967);
      chk("B63_pos", int'(th_positive), 4095);
      chk("B63_delta", int'(th_delta), 4030);
      tick();
`else
      send(0, 4); tick();
      chk("B0_minus", int'(th_minus), 4064);
      chk("B0_pos", int'(th_positive), 96);
      chk("B0_delta", int'(th_delta), 0);
      tick();
`endif

      th_wr_ready = 1'b0;
      wr_cycles = 0;
      send(20, 6);
      repeat (6) tick();
      chk("C_ready_held_low", int'(peak_ready), 0);
      th_wr_ready = 1'b1;
      tick();
      chk("C_wr_cycles", wr_cycles, 6);

      pulse_fs();
      d = done_cnt;
      for (int i = 0; i < 16; i++) wr((i * 5) % 64, i);
      chk("D_done_pulse", int'(frame_done), 1);
      tick();
      chk("D_done_once", done_cnt - d, 1);
      chk("D_done_low", int'(frame_done), 0);

      pulse_fs();
      for (int i = 0; i < 15; i++) wr(i + 1, i);
      send(33, 15);
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("E_no_done", int'(frame_done), 0);
      d = done_cnt;
      for (int i = 0; i < 15; i++) wr(i, i);
      tick();
      chk("E_cnt_cleared", done_cnt - d, 0);
      wr(2, 15);
      chk("E_done_after_16", int'(frame_done), 1);

      pulse_fs();
      for (int i = 0; i < 3; i++) wr(40, i);
      w0 = wr_cycles;
      send(7, 20);
      tick();
      chk("F_err", int'(err_pix), 1);
      chk("F_no_wr", int'(th_wr_en), 0);
      chk("F_ready", int'(peak_ready), 1);
      tick();
      chk("F_no_wr_cycles", wr_cycles - w0, 0);
      d = done_cnt;
      for (int i = 3; i < 15; i++) wr(50, i);
      tick();
      chk("F_cnt_unchanged", done_cnt - d, 0);
      wr(51, 15);
      chk("F_done", int'(frame_done), 1);
      pulse_fs();
      chk("F_err_cleared", int'(err_pix), 0);

      for (int i = 0; i < 5; i++) wr(12, i);
      th_wr_ready = 1'b0;
      send(9, 2);
      tick(); tick();
      chk("G_in_write", int'(th_wr_en), 1);
      #1 res = 1'b1;
      #1;
      chk("G_wr_en_dropped", int'(th_wr_en), 0);
      chk("G_ready_low", int'(peak_ready), 0);
      chk("G_done_low", int'(frame_done), 0);
      tick();
      th_wr_ready = 1'b1;
      res = 1'b0;
      tick();
      d = done_cnt;
      for (int i = 0; i < 15; i++) wr(i + 20, i);
      tick();
      chk("G_cnt_reset", done_cnt - d, 0);
      wr(30, 15);
      chk("G_done", int'(frame_done), 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alg_thresh_sched.md
ALG_THRESH_SCHED -- requirements
Module: alg_thresh_sched

Interface
REQ-001 SHALL have parameter Nb, default 6: histogram bin-index width.
REQ-002 SHALL have parameter Np, default 12: threshold precision width, Np > Nb+1.
REQ-003 SHALL have parameter PIXEL_NUM, default 16: pixels per frame.
REQ-004 SHALL have parameter PW, default 4: pixel-index width, 2^PW >= PIXEL_NUM.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge
- res  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse; clears frame counter
- peak_valid  in  1  peak result offered
- peak_ch  in  Nb  peak bin index
- peak_pix  in  PW  pixel index of peak
- peak_ready  out  1  scheduler can accept a peak
- th_wr_en  out  1  threshold write valid
- th_wr_ready  in  1  threshold table accepts write
- th_wr_addr  out  PW  pixel index being written
- th_minus  out  Np  lower gate threshold
- th_positive  out  Np  upper gate threshold
- th_delta  out  Np  gate delta
- frame_done  out  1  one-cycle pulse, frame complete
- err_pix  out  1  sticky: peak_pix >= PIXEL_NUM seen

Function
REQ-006 SHALL implement FSM states IDLE, CALC, WRITE.
REQ-007 IDLE: peak_ready=1; peak_valid=1 SHALL capture peak_ch/peak_pix and move to CALC; otherwise stay.
REQ-008 peak_ready SHALL be 0 in CALC and WRITE.
REQ-009 CALC: one cycle; SHALL register th_minus, th_positive, th_delta, th_wr_addr; go to WRITE.
REQ-010 WRITE: th_wr_en=1 with data stable; stay until th_wr_ready=1; on that cycle go to IDLE.
REQ-011 Min accept-to-accept spacing: 3 cycles; th_wr_en first asserts 2 cycles after the accept edge.
REQ-012 Arithmetic, all unsigned Np bits, modulo 2^Np: CH = (peak_ch << (Np-Nb)) + 2^(Np-Nb-1); SB = 2^(Np-Nb); UB = 2^Np-1.
REQ-013 Default bounds: th_minus = CH-SB, th_positive = CH+SB.
REQ-014 th_delta SHALL be th_minus + th_positive - ((th_positive >> Nb) << Nb), truncated to Np.
REQ-015 Frame counter (PW+1 bits) SHALL increment on each completed write (th_wr_en & th_wr_ready).
REQ-016 The completed write that brings the counter to PIXEL_NUM SHALL pulse frame_done next cycle and clear the counter.
REQ-017 frame_start SHALL clear the counter; if coincident with a completed write, clear wins and no frame_done.
REQ-018 frame_start SHALL NOT abort an in-flight CALC/WRITE.
REQ-019 peak_pix >= PIXEL_NUM SHALL be accepted, not written (WRITE skipped, return to IDLE after CALC), not counted, and set err_pix.
REQ-020 err_pix SHALL clear only on reset or frame_start.

Reset
REQ-021 res=1 SHALL asynchronously force state IDLE, counter 0, all outputs 0 except peak_ready.
REQ-022 peak_ready SHALL be 0 while res=1 and 1 from the first clk edge after release.
REQ-023 Reset mid-WRITE SHALL drop the pending write; no frame_done.

Configuration
REQ-024 Macro ALG_CLAMP_EN SHALL control window clamping.
REQ-025 Defined: if CH < SB then th_minus=0, th_positive=2*SB; else if CH > UB-SB then th_positive=UB, th_minus=UB-2*SB; else REQ-013.
REQ-026 Undefined: REQ-013 always, wrapping modulo 2^Np; th_delta per REQ-014 on wrapped values.

Verification (Nb=6, Np=12, PIXEL_NUM=16)
REQ-027 peak_ch=10, pix=3, th_wr_ready=1 -> th_wr_en 2 cycles after accept, addr 3, minus=608, positive=736, delta=640.
REQ-028 ALG_CLAMP_EN defined, peak_ch=0 -> minus=0, positive=128, delta=0; peak_ch=63 -> minus=3967, positive=4095, delta=4030.
REQ-029 ALG_CLAMP_EN undefined, peak_ch=0 -> minus=4064, positive=96, delta=0.
REQ-030 th_wr_ready low 5 cycles in WRITE -> th_wr_en and data held 6 cycles, peak_ready=0 throughout, single count.
REQ-031 16 peaks pix 0..15 -> exactly one frame_done after 16th write; frame_start coincident with 16th write -> no frame_done, counter 0.
REQ-032 peak_pix=20 -> no th_wr_en, err_pix=1, counter unchanged; res asserted mid-WRITE -> th_wr_en=0 immediately, counter 0.
